// File: rtl/ram_sched_pkg.sv
// Shared types for the RAM access scheduler.
// Holds the FSM state enum and the 2-bit RAM command codes.
package ram_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_TX,
    DONE
  } state_e;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_WR_ADDR = 2'b00;
  localparam cmd_t CMD_WR_DATA = 2'b01;
  localparam cmd_t CMD_RD_ADDR = 2'b10;
  localparam cmd_t CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports: req (requests), ptr (priority start), grant (one-hot), idx (encoded).
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  int   j;
  logic found;

  // Scan upward from ptr with wrap-around; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_access_scheduler.sv
// Shares the SPI RAM command port between N_REQ round-robin requesters.
// Ports: clk, rst (async high); req/req_we/req_addr/req_wdata in;
//   done/rdata/err/busy out; ram_din/ram_rx_valid to RAM;
//   ram_dout/ram_tx_valid from RAM.
// Option: define RAM_TIMEOUT_EN to bound WAIT_TX to TIMEOUT_CYCLES.
module ram_access_scheduler
  import ram_sched_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_SIZE      = 8,
  parameter int MEM_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_SIZE-1:0] req_addr,
  input  logic [N_REQ*MEM_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]           done,
  output logic [MEM_WIDTH-1:0]       rdata,
  output logic                       err,
  output logic                       busy,
  output logic [MEM_WIDTH+1:0]       ram_din,
  output logic                       ram_rx_valid,
  input  logic [MEM_WIDTH-1:0]       ram_dout,
  input  logic                       ram_tx_valid
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e state, state_n;

  logic [IW-1:0]        ptr;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        gidx;
  logic [N_REQ-1:0]     grant;
  logic                 any_req;
  logic                 we_q;
  logic [MEM_WIDTH-1:0] wdata_q;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [MEM_WIDTH-1:0] sel_wdata;
  logic                 tx_hit;
  logic                 tmo;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(grant),
    .idx  (gidx)
  );

  assign any_req = |grant;

  always_comb begin
    sel_we    = req_we[gidx];
    sel_addr  = req_addr[int'(gidx)*ADDR_SIZE +: ADDR_SIZE];
    sel_wdata = req_wdata[int'(gidx)*MEM_WIDTH +: MEM_WIDTH];
  end

  assign tx_hit = (state == WAIT_TX) && ram_tx_valid;

`ifdef RAM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Data arriving on the last counted cycle beats the timeout.
  assign tmo = (state == WAIT_TX) && !ram_tx_valid &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= tmo;
      if (state != WAIT_TX) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any_req) state_n = ADDR;
      ADDR:    state_n = DATA;
      DATA:    state_n = we_q ? DONE : WAIT_TX;
      WAIT_TX: if (tx_hit || tmo) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      done         <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      state        <= state_n;
      busy         <= (state_n != IDLE);
      ram_rx_valid <= (state_n == ADDR) || (state_n == DATA);
      done         <= '0;
      if (state == IDLE && any_req) begin
        owner   <= gidx;
        we_q    <= sel_we;
        wdata_q <= sel_wdata;
        ram_din <= {sel_we ? CMD_WR_ADDR : CMD_RD_ADDR,
                    MEM_WIDTH'(sel_addr)};
      end
      if (state == ADDR) begin
        ram_din <= {we_q ? CMD_WR_DATA : CMD_RD_DATA,
                    we_q ? wdata_q : {MEM_WIDTH{1'b0}}};
      end
      if (state_n == DONE) done[owner] <= 1'b1;
      if (tx_hit)   rdata <= ram_dout;
      else if (tmo) rdata <= '0;
      if (state == DONE) begin
        ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Directed self-checking bench for ram_access_scheduler.
// Covers reset, write, read, rotation, abort, spurious tx, timeout.
module tb_ram_access_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] prev_din;
  bit         prev_ok = 0;
  int         exp_own;

  ram_access_scheduler #(
    .N_REQ         (2),
    .ADDR_SIZE     (8),
    .MEM_WIDTH     (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .busy        (busy),
    .ram_din     (ram_din),
    .ram_rx_valid(ram_rx_valid),
    .ram_dout    (ram_dout),
    .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ram_din must hold whenever the strobe is low.
  always @(negedge clk) begin
    if (rst) begin
      prev_ok = 0;
    end else begin
      if (prev_ok && !ram_rx_valid) chk("din_stable", ram_din, prev_din);
      prev_din = ram_din;
      prev_ok  = 1;
    end
  end

  initial begin
    rst          = 1'b1;
    req          = 2'b00;
    req_we       = 2'b00;
    req_addr     = '0;
    req_wdata    = '0;
    ram_dout     = '0;
    ram_tx_valid = 1'b0;
    step();
    step();
    chk("rst_rxv", ram_rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Requester 0 write 3C <- A5
    req_we    = 2'b01;
    req_addr  = 16'h003C;
    req_wdata = 16'h00A5;
    req       = 2'b01;
    step();
    chk("wr_addr_din", ram_din, 10'h03C);
    chk("wr_addr_rxv", ram_rx_valid, 1);
    chk("wr_busy", busy, 1);
    req_wdata = 16'h0011;
    step();
    chk("wr_data_din", ram_din, 10'h1A5);
    chk("wr_data_rxv", ram_rx_valid, 1);
    chk("wr_done_early", done, 0);
    step();
    chk("wr_done", done, 2'b01);
    chk("wr_rxv_off", ram_rx_valid, 0);
    req = 2'b00;
    step();
    chk("wr_done_pulse", done, 0);
    chk("wr_idle", busy, 0);

    // Requester 1 read 3C, RAM answers A5 two cycles after RD_DATA
    req_we   = 2'b00;
    req_addr = 16'h3C00;
    req      = 2'b10;
    step();
    chk("rd_addr_din", ram_din, 10'h23C);
    step();
    chk("rd_data_din", ram_din, 10'h300);
    step();
    chk("rd_wait_rxv", ram_rx_valid, 0);
    chk("rd_wait_busy", busy, 1);
    step();
    chk("rd_wait_done", done, 0);
    ram_dout     = 8'hA5;
    ram_tx_valid = 1'b1;
    step();
    chk("rd_done", done, 2'b10);
    chk("rd_rdata", rdata, 8'hA5);
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h00;
    req          = 2'b00;
    step();
    chk("rd_done_pulse", done, 0);
    chk("rd_rdata_hold", rdata, 8'hA5);

    // Spurious tx while idle
    ram_dout     = 8'hFF;
    ram_tx_valid = 1'b1;
    step();
    step();
    chk("spur_rdata", rdata, 8'hA5);
    chk("spur_busy", busy, 0);
    chk("spur_done", done, 0);
    ram_tx_valid = 1'b0;
    ram_dout     = 8'h00;

    // Abort mid-ADDR: requester 1 read, pointer now 0
    req = 2'b10;
    step();
    chk("abort_pre_rxv", ram_rx_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_rxv", ram_rx_valid, 0);
    chk("abort_busy", busy, 0);
    req_we    = 2'b11;
    req_addr  = 16'h3412;
    req_wdata = 16'h7856;
    req       = 2'b11;
    step();
    chk("abort_done", done, 0);
    rst = 1'b0;

    // Both requesting: owners 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      exp_own = t % 2;
      step();
      chk("rot_addr_din", ram_din, (exp_own == 0) ? 10'h012 : 10'h034);
      step();
      chk("rot_data_din", ram_din, (exp_own == 0) ? 10'h156 : 10'h178);
      step();
      chk("rot_done", done, (exp_own == 0) ? 2'b01 : 2'b10);
      if (t == 3) req = 2'b00;
      step();
      chk("rot_idle_gap", busy, 0);
    end

`ifdef RAM_TIMEOUT_EN
    // Silent RAM on a requester 0 read
    req_we   = 2'b00;
    req_addr = 16'h0044;
    req      = 2'b01;
    step();
    step();
    step();
    chk("tmo_wait", busy, 1);
    for (int c = 1; c < 16; c++) step();
    chk("tmo_early", done, 0);
    step();
    chk("tmo_done", done, 2'b01);
    chk("tmo_err", err, 1);
    chk("tmo_rdata", rdata, 0);
    req = 2'b00;
    step();
    chk("tmo_err_pulse", err, 0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
